// File: rtl/lfsr_arbiter.sv
// Round-robin scheduler sharing one LFSR step engine among NREQ requesters,
// each with a private state/tap context and a single registered response slot.
module lfsr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter logic [WIDTH-1:0] TAP_DEFAULT = 8'hB5,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_load,
    input  logic [NREQ*WIDTH-1:0] req_seed,
    input  logic [NREQ*WIDTH-1:0] req_tap,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready
);

    typedef enum logic {EMPTY, FULL} rsp_state_t;

    rsp_state_t       rsp_state;
    rsp_state_t       rsp_state_next;
    logic [WIDTH-1:0] ctx_state [NREQ];
    logic [WIDTH-1:0] ctx_tap   [NREQ];
    logic [IDW-1:0]   ptr;

    logic             can_issue;
    logic             found;
    logic             grant;
    logic [IDW-1:0]   grant_id;
    int               idx;

    logic [WIDTH-1:0] cur_state;
    logic [WIDTH-1:0] cur_tap;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] tap_in;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] new_state;

    assign can_issue = (rsp_state == EMPTY) || rsp_ready;

    // Search starts at ptr and wraps, so the last-served requester goes to the back.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
    end

    assign grant     = found && can_issue && !reset;
    assign req_ready = grant ? (NREQ'(1) << grant_id) : '0;

    // Shared datapath; a zero result is forced to 1 so no context can lock up.
    always_comb begin
        cur_state = ctx_state[grant_id];
        cur_tap   = ctx_tap[grant_id];
        seed_in   = req_seed[int'(grant_id)*WIDTH +: WIDTH];
        tap_in    = req_tap[int'(grant_id)*WIDTH +: WIDTH];
        raw       = {cur_state[WIDTH-2:0], ^(cur_state & cur_tap)};
        if (req_load[grant_id]) begin
            new_state = (seed_in == '0) ? WIDTH'(1) : seed_in;
        end else begin
            new_state = (raw == '0) ? WIDTH'(1) : raw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                ctx_state[i] <= WIDTH'(1);
                ctx_tap[i]   <= TAP_DEFAULT;
            end
        end else if (grant) begin
            ctx_state[grant_id] <= new_state;
            if (req_load[grant_id]) begin
                ctx_tap[grant_id] <= tap_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else if (grant) begin
            ptr      <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
            rsp_id   <= grant_id;
            rsp_data <= new_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_state <= EMPTY;
        end else begin
            rsp_state <= rsp_state_next;
        end
    end

    always_comb begin
        rsp_state_next = rsp_state;
        if (grant) begin
            rsp_state_next = FULL;
        end else if (rsp_state == FULL && rsp_ready) begin
            rsp_state_next = EMPTY;
        end
    end

    always_comb begin
        rsp_valid = (rsp_state == FULL);
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter: a reference model predicts each grant and
// pushes the expected response into a scoreboard queue checked against the DUT.
module tb_lfsr_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_load;
    logic [N*W-1:0] req_seed;
    logic [N*W-1:0] req_tap;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_state [N];
    logic [W-1:0] m_tap   [N];
    int           m_ptr;
    logic [9:0]   sb [$];

    lfsr_arbiter #(.WIDTH(W), .NREQ(N), .TAP_DEFAULT(8'hB5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_load(req_load),
        .req_seed(req_seed), .req_tap(req_tap), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_step(input logic [W-1:0] s, input logic [W-1:0] t);
        logic [W-1:0] r;
        r = {s[W-2:0], ^(s & t)};
        return (r == 0) ? 8'h01 : r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 8'h01;
            m_tap[i]   = 8'hB5;
        end
        m_ptr = 0;
        sb.delete();
    endtask

    // One cycle: check registered outputs, drive inputs, predict the grant.
    task automatic tick(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [N*W-1:0] seed, input logic [N*W-1:0] tap,
                        input logic rr);
        logic [9:0]   front;
        logic [N-1:0] exp_ready;
        logic [W-1:0] s;
        int           g;
        int           ix;
        bit           can;
        @(negedge clk);
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            front = sb[0];
            check("rsp_id", {30'd0, rsp_id}, {30'd0, front[9:8]});
            check("rsp_data", {24'd0, rsp_data}, {24'd0, front[7:0]});
        end
        req_valid = v;
        req_load  = l;
        req_seed  = seed;
        req_tap   = tap;
        rsp_ready = rr;
        #1;
        can = (sb.size() == 0) || rr;
        g = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                ix = (m_ptr + k) % N;
                if (g < 0 && v[ix]) g = ix;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        if (sb.size() != 0 && rr) void'(sb.pop_front());
        if (g >= 0) begin
            if (l[g]) begin
                s = seed[g*W +: W];
                m_state[g] = (s == 0) ? 8'h01 : s;
                m_tap[g]   = tap[g*W +: W];
            end else begin
                m_state[g] = model_step(m_state[g], m_tap[g]);
            end
            sb.push_back({2'(g), m_state[g]});
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic applyStimulus(input int id, input bit load, input logic [W-1:0] seed,
                                 input logic [W-1:0] tap, input logic rr);
        logic [N*W-1:0] sv;
        logic [N*W-1:0] tv;
        sv = '0;
        tv = '0;
        sv[id*W +: W] = seed;
        tv[id*W +: W] = tap;
        tick(N'(1 << id), load ? N'(1 << id) : '0, sv, tv, rr);
    endtask

    task automatic idle(input logic rr);
        tick('0, '0, '0, '0, rr);
    endtask

    initial begin
        model_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_load  = '0;
        req_seed  = '0;
        req_tap   = '0;
        rsp_ready = 1'b0;
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("reset_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'hF;
        #1;
        check("reset_req_ready_valid", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Load then four steps on requester 0: 01, 03, 07, 0E, 1D.
        applyStimulus(0, 1'b1, 8'h01, 8'hB5, 1'b1);
        repeat (4) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(1'b1);

        // Zero seed and zero raw result both become 1.
        applyStimulus(2, 1'b1, 8'h00, 8'hB5, 1'b1);
        applyStimulus(3, 1'b1, 8'h80, 8'h01, 1'b1);
        applyStimulus(3, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(1'b1);

        // All four stepping together rotate 0,1,2,3,...
        repeat (8) tick(4'hF, 4'h0, '0, '0, 1'b1);

        // Backpressure holds the response and blocks grants, then issue resumes.
        repeat (3) tick(4'hF, 4'h0, '0, '0, 1'b0);
        repeat (2) tick(4'hF, 4'h0, '0, '0, 1'b1);
        idle(1'b1);

        // Requester 1 load interleaved with requester 0 steps.
        applyStimulus(0, 1'b1, 8'h01, 8'hB5, 1'b1);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1, 1'b1, 8'hAA, 8'hC3, 1'b1);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(1'b1);

        // Reset while a response is pending.
        applyStimulus(2, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_rsp_data", {24'd0, rsp_data}, 32'd0);
        check("midreset_req_ready", {28'd0, req_ready}, 32'd0);
        model_reset();
        #1;
        reset = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b1);
        check("post_reset_expect", {24'd0, m_state[0]}, 32'h03);
        idle(1'b1);
        idle(1'b1);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
